// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FP add/round sequencer control.
package fpu_ctrl_pkg;

    // Stage-1 sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DNRM = 2'd2
    } s1_state_e;

    // Contents of one pipeline stage
    typedef struct packed {
        logic       valid;
        logic       id;
        logic [3:0] op;
        logic [2:0] rm;
        logic       p;
        logic       denorm;
    } stage_t;

    // Flag bit positions in the 5-bit {UF,0,OF,NV,NX} vector
    localparam int FLAG_NX = 0;
    localparam int FLAG_NV = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 4;

    // op_type encodings
    localparam logic [3:0] OP_FADD = 4'd0;
    localparam logic [3:0] OP_FSUB = 4'd1;
    localparam logic [3:0] OP_FCVT = 4'd2;
    localparam logic [3:0] OP_FRND = 4'd3;

    // Keep only the defined flag positions; bit 3 is always reported as 0
    function automatic logic [4:0] flag_clean(input logic [4:0] raw);
        logic [4:0] mask;
        mask = 5'd0;
        mask[FLAG_NX] = 1'b1;
        mask[FLAG_NV] = 1'b1;
        mask[FLAG_OF] = 1'b1;
        mask[FLAG_UF] = 1'b1;
        return raw & mask;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the side that wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;

    // Grant selection: tie goes to the pointer side, a lone request wins outright
    always_comb begin
        gnt_o = 2'b00;
        if (!en_i) begin
            gnt_o = 2'b00;
        end else if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

    // Pointer moves to the requester that did not just win
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (gnt_o != 2'b00) begin
            ptr_q <= ~gnt_o[1];
        end else begin
            ptr_q <= ptr_q;
        end
    end

endmodule

// File: rtl/fpadd_seq_ctrl.sv
// Three-stage sequencing control for a shared FP add/round datapath with
// two requesters, denormal extra cycle, result back-pressure and flags.
module fpadd_seq_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int DENORM_XTRA = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [2:0] req0_rm,
    input  logic       req0_p,
    input  logic       req0_denorm,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [2:0] req1_rm,
    input  logic       req1_p,
    input  logic       req1_denorm,
    output logic [3:0] dp_op,
    output logic [2:0] dp_rm,
    output logic       dp_p,
    output logic       dp_denorm_in,
    output logic       dp_s1_en,
    output logic       dp_s2_en,
    output logic       dp_s3_en,
    input  logic [4:0] dp_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic [4:0] res_flags,
    input  logic       flush,
    input  logic       fflags_clr,
    output logic [4:0] fflags_acc,
    output logic       busy
);

    stage_t     s1_q, s2_q, s3_q;
    s1_state_e  state_q;
    logic [4:0] acc_q;

    logic       stall_s, hs_s, s1_adv_s, grant_ok_s, accept_s, new_dn_s;
    logic [1:0] gnt_s;
    stage_t     new_op_s;
    logic [4:0] flags_s;

    // Back-pressure freezes everything; stage 1 leaves unless it is in its extra denormal cycle
    assign stall_s    = s3_q.valid && !res_ready;
    assign hs_s       = s3_q.valid && res_ready;
    assign s1_adv_s   = s1_q.valid && !stall_s && (state_q != ST_DNRM);
    assign grant_ok_s = reset && !flush && !stall_s && (!s1_q.valid || s1_adv_s);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i ({req1_valid, req0_valid}),
        .en_i  (grant_ok_s),
        .gnt_o (gnt_s)
    );

    assign accept_s = gnt_s[0] | gnt_s[1];

    // Capture the fields of whichever requester won
    always_comb begin
        new_op_s        = '0;
        new_op_s.valid  = 1'b1;
        if (gnt_s[1]) begin
            new_op_s.id     = 1'b1;
            new_op_s.op     = req1_op;
            new_op_s.rm     = req1_rm;
            new_op_s.p      = req1_p;
            new_op_s.denorm = req1_denorm;
        end else begin
            new_op_s.id     = 1'b0;
            new_op_s.op     = req0_op;
            new_op_s.rm     = req0_rm;
            new_op_s.p      = req0_p;
            new_op_s.denorm = req0_denorm;
        end
    end

    assign new_dn_s = new_op_s.denorm && (DENORM_XTRA != 0);
    assign flags_s  = s3_q.valid ? flag_clean(dp_flags) : 5'd0;

    // Stage registers: flush kills valids, back-pressure holds, otherwise shift
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (flush) begin
            s1_q.valid <= 1'b0;
            s2_q.valid <= 1'b0;
            s3_q.valid <= 1'b0;
        end else if (!stall_s) begin
            s3_q <= s2_q;
            if (s1_adv_s) begin
                s2_q <= s1_q;
            end else begin
                s2_q.valid <= 1'b0;
            end
            if (accept_s) begin
                s1_q <= new_op_s;
            end else if (s1_adv_s) begin
                s1_q.valid <= 1'b0;
            end else begin
                s1_q <= s1_q;
            end
        end else begin
            s1_q <= s1_q;
            s2_q <= s2_q;
            s3_q <= s3_q;
        end
    end

    // Stage-1 FSM: a denormal op spends one extra cycle in DNRM before it may leave
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else if (stall_s) begin
            state_q <= state_q;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (accept_s) begin
                        state_q <= new_dn_s ? ST_DNRM : ST_RUN;
                    end else if (s1_adv_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_DNRM: state_q <= ST_RUN;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky flag accumulator; a clear keeps only the flags of a coincident handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= 5'd0;
        end else if (fflags_clr) begin
            acc_q <= hs_s ? flags_s : 5'd0;
        end else if (hs_s) begin
            acc_q <= acc_q | flags_s;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign req0_ready   = gnt_s[0];
    assign req1_ready   = gnt_s[1];
    assign dp_op        = s1_q.op;
    assign dp_p         = s1_q.p;
    assign dp_denorm_in = s1_q.denorm;
    assign dp_rm        = s3_q.rm;
    assign dp_s1_en     = s1_q.valid && !stall_s;
    assign dp_s2_en     = s1_adv_s;
    assign dp_s3_en     = s2_q.valid && !stall_s;
    assign res_valid    = s3_q.valid;
    assign res_id       = s3_q.valid & s3_q.id;
    assign res_flags    = flags_s;
    assign fflags_acc   = acc_q;
    assign busy         = s1_q.valid | s2_q.valid | s3_q.valid;

endmodule
